pixel_pack_fsm: RTL and testbench

- Parametrised successor to the edge-pixel capture FSMs. Packs a streaming pixel bus of PIXEL_BITS bits/pixel into DATA_WIDTH-bit words and writes them to the frame buffer RAM at sequential word addresses.
- Adds start-of-frame sync, arm/continuous capture modes, tail-word flush with zero padding, abort, and short-frame error detection.
- Accepts one pixel per clock with no inter-word bubble. Sits between the Canny output and the UART frame buffer.

---
 rtl/pixel_pack_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_pixel_pack_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pack_fsm.sv
// rtl/pixel_pack_fsm.sv - packs a pixel stream into RAM words at sequential addresses
//
// Purpose: captures one frame of PIXEL_BITS-wide pixels (one per clock when
// pix_de is high), packs them LSB-first into DATA_WIDTH-bit words and issues
// one RAM write per completed word. The final word of a frame is flushed with
// zero padding in its unfilled slots.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   arm               pulse: capture the next frame
//   cont_mode         level: re-arm automatically after every frame
//   abort             pulse: drop the current frame, return to idle
//   pix_de, pix_sof   pixel valid, first pixel of frame (qualified by pix_de)
//   pix_data          pixel value
//   we, wData, wAddr  RAM write strobe, packed word, word address
//   frame_tick        pulse alongside the final write of a frame
//   err_short         pulse when a new frame starts before the current one ends
//   busy              high while armed or capturing
module pixel_pack_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PIXEL_BITS = 1,
    parameter int IMG_WIDTH  = 176,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_WIDTH =
        (((IMG_WIDTH * IMG_HEIGHT) + (DATA_WIDTH / PIXEL_BITS) - 1) / (DATA_WIDTH / PIXEL_BITS) > 1)
        ? $clog2(((IMG_WIDTH * IMG_HEIGHT) + (DATA_WIDTH / PIXEL_BITS) - 1) / (DATA_WIDTH / PIXEL_BITS))
        : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  cont_mode,
    input  logic                  abort,
    input  logic                  pix_de,
    input  logic                  pix_sof,
    input  logic [PIXEL_BITS-1:0] pix_data,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wData,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic                  frame_tick,
    output logic                  err_short,
    output logic                  busy
);

    localparam int PPW          = DATA_WIDTH / PIXEL_BITS;
    localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W        = (TOTAL_PIXELS > 1) ? $clog2(TOTAL_PIXELS) : 1;
    localparam int SLOT_W       = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(TOTAL_PIXELS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  tick_q, tick_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    // Counter values the accepted pixel is applied to: the live counters, or
    // zero when this pixel opens a new frame (sof from ARMED or early restart).
    logic                  accept;
    logic [DATA_WIDTH-1:0] base_pack;
    logic [SLOT_W-1:0]     base_slot;
    logic [PIX_W-1:0]      base_pix;
    logic [ADDR_WIDTH-1:0] base_word;
    logic [DATA_WIDTH-1:0] word_v;

    always_comb begin
        state_d    = state_q;
        pack_d     = pack_q;
        slot_d     = slot_q;
        pix_cnt_d  = pix_cnt_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        accept     = 1'b0;
        base_pack  = pack_q;
        base_slot  = slot_q;
        base_pix   = pix_cnt_q;
        base_word  = word_idx_q;
        word_v     = '0;

        if (abort) begin
            state_d    = IDLE;
            pack_d     = '0;
            slot_d     = '0;
            pix_cnt_d  = '0;
            word_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm || cont_mode) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (pix_de && pix_sof) begin
                        accept    = 1'b1;
                        base_pack = '0;
                        base_slot = '0;
                        base_pix  = '0;
                        base_word = '0;
                        state_d   = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pix_de) begin
                        accept = 1'b1;
                        if (pix_sof) begin
                            // Partial word is discarded; this pixel restarts at address 0.
                            err_d     = 1'b1;
                            base_pack = '0;
                            base_slot = '0;
                            base_pix  = '0;
                            base_word = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (accept) begin
                word_v = base_pack;
                word_v[int'(base_slot) * PIXEL_BITS +: PIXEL_BITS] = pix_data;

                if (base_pix == LAST_PIX) begin
                    // Tail flush: unfilled slots are still zero in base_pack.
                    we_d       = 1'b1;
                    wdata_d    = word_v;
                    waddr_d    = base_word;
                    tick_d     = 1'b1;
                    pack_d     = '0;
                    slot_d     = '0;
                    pix_cnt_d  = '0;
                    word_idx_d = '0;
                    state_d    = cont_mode ? ARMED : IDLE;
                end else if (base_slot == LAST_SLOT) begin
                    we_d       = 1'b1;
                    wdata_d    = word_v;
                    waddr_d    = base_word;
                    pack_d     = '0;
                    slot_d     = '0;
                    pix_cnt_d  = base_pix + PIX_W'(1);
                    word_idx_d = base_word + ADDR_WIDTH'(1);
                end else begin
                    pack_d     = word_v;
                    slot_d     = base_slot + SLOT_W'(1);
                    pix_cnt_d  = base_pix + PIX_W'(1);
                    word_idx_d = base_word;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pack_q     <= '0;
            slot_q     <= '0;
            pix_cnt_q  <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_q     <= pack_d;
            slot_q     <= slot_d;
            pix_cnt_q  <= pix_cnt_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign we         = we_q;
    assign wData      = wdata_q;
    assign wAddr      = waddr_q;
    assign frame_tick = tick_q;
    assign err_short  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_pack_fsm.sv
// tb/tb_pixel_pack_fsm.sv - scoreboard bench for pixel_pack_fsm
module tb_pixel_pack_fsm;

    localparam int PPW = 8;
    localparam int PB  = 1;
    localparam int TOT = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arm = 1'b0, cont_mode = 1'b0, abort = 1'b0;
    logic       pix_de = 1'b0, pix_sof = 1'b0;
    logic [0:0] pix_data = '0;
    logic       we, frame_tick, err_short, busy;
    logic [7:0] wData;
    logic [0:0] wAddr;

    logic       reset2 = 1'b1;
    logic       arm2 = 1'b0, cont2 = 1'b0, abort2 = 1'b0;
    logic       de2 = 1'b0, sof2 = 1'b0;
    logic [1:0] data2 = '0;
    logic       we2, tick2, err2, busy2;
    logic [7:0] wData2;
    logic [0:0] wAddr2;

    always #5 clk = ~clk;

    pixel_pack_fsm #(.DATA_WIDTH(8), .PIXEL_BITS(1), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
        .clk(clk), .reset(reset), .arm(arm), .cont_mode(cont_mode), .abort(abort),
        .pix_de(pix_de), .pix_sof(pix_sof), .pix_data(pix_data),
        .we(we), .wData(wData), .wAddr(wAddr), .frame_tick(frame_tick),
        .err_short(err_short), .busy(busy)
    );

    pixel_pack_fsm #(.DATA_WIDTH(8), .PIXEL_BITS(2), .IMG_WIDTH(3), .IMG_HEIGHT(1)) dut2 (
        .clk(clk), .reset(reset2), .arm(arm2), .cont_mode(cont2), .abort(abort2),
        .pix_de(de2), .pix_sof(sof2), .pix_data(data2),
        .we(we2), .wData(wData2), .wAddr(wAddr2), .frame_tick(tick2),
        .err_short(err2), .busy(busy2)
    );

    typedef struct {
        int addr;
        int data;
        bit tick;
    } wr_t;

    typedef struct {
        bit busy;
        bit we;
        bit err;
    } cyc_t;

    wr_t  wr_q[$];
    cyc_t cyc_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capturing; px holds the frame so far.
    int mode = 0;
    int px[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Emit a write once the frame so far fills a word or reaches its last pixel.
    task automatic emit(input bit c, output bit w);
        int  n, base, data;
        wr_t e;
        n = px.size();
        w = 1'b0;
        if ((n % PPW == 0) || (n == TOT)) begin
            base = ((n - 1) / PPW) * PPW;
            data = 0;
            for (int i = base; i < n; i++) data += px[i] << ((i - base) * PB);
            e.addr = base / PPW;
            e.data = data;
            e.tick = (n == TOT);
            wr_q.push_back(e);
            w = 1'b1;
            if (n == TOT) begin
                px.delete();
                mode = c ? 1 : 0;
            end
        end
    endtask

    task automatic model(input bit a, input bit c, input bit ab, input bit de, input bit sof, input int d);
        cyc_t e;
        e.we  = 1'b0;
        e.err = 1'b0;
        if (ab) begin
            mode = 0;
            px.delete();
        end else if (mode == 0) begin
            if (a || c) mode = 1;
        end else if (mode == 1) begin
            if (de && sof) begin
                px.delete();
                px.push_back(d);
                mode = 2;
                emit(c, e.we);
            end
        end else begin
            if (de) begin
                if (sof) begin
                    e.err = 1'b1;
                    px.delete();
                end
                px.push_back(d);
                emit(c, e.we);
            end
        end
        e.busy = (mode != 0);
        cyc_q.push_back(e);
    endtask

    task automatic step(input bit a, input bit c, input bit ab, input bit de, input bit sof, input int d);
        @(negedge clk);
        arm       = a;
        cont_mode = c;
        abort     = ab;
        pix_de    = de;
        pix_sof   = sof;
        pix_data  = d[0];
        model(a, c, ab, de, sof, d);
    endtask

    task automatic idle(input int n, input bit c);
        for (int i = 0; i < n; i++) step(1'b0, c, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic pixels(input int n, input bit c, input bit first_sof);
        for (int i = 0; i < n; i++)
            step(1'b0, c, 1'b0, 1'b1, first_sof && (i == 0), int'($urandom_range(0, 1)));
    endtask

    // Monitor: per-cycle strobes from cyc_q, write contents from wr_q.
    initial begin
        cyc_t e;
        wr_t  w;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("busy", 32'(busy), 32'(e.busy));
                chk("we", 32'(we), 32'(e.we));
                chk("err_short", 32'(err_short), 32'(e.err));
                if (we) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wAddr, wData);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wAddr", 32'(wAddr), 32'(w.addr));
                        chk("wData", 32'(wData), 32'(w.data));
                        chk("frame_tick", 32'(frame_tick), 32'(w.tick));
                    end
                end else begin
                    chk("frame_tick_idle", 32'(frame_tick), 32'd0);
                end
            end
        end
    end

    initial begin
        int s1[12] = '{1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        bit rc;

        #2;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wData", 32'(wData), 32'd0);
        chk("rst_wAddr", 32'(wAddr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_err", 32'(err_short), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed frame: words 8'h8D then 8'h0F with frame_tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b1, i == 0, s1[i]);
        idle(2, 1'b0);

        // Pixels in IDLE (even with sof) and pre-sof pixels in ARMED are ignored.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pixels(12, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Continuous mode: two frames, one idle cycle between.
        idle(1, 1'b1);
        pixels(12, 1'b1, 1'b1);
        idle(1, 1'b1);
        pixels(12, 1'b1, 1'b1);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Early restart at pixel 5.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pixels(5, 1'b0, 1'b1);
        pixels(12, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Abort at pixel 9, with a pixel and arm in the same cycle; then re-arm.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pixels(9, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pixels(12, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Randomized traffic.
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) rc = ~rc;
            step($urandom_range(0, 19) == 0, rc, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 85, $urandom_range(0, 24) == 0,
                 int'($urandom_range(0, 1)));
        end
        idle(2, 1'b0);

        // Asynchronous reset mid-frame: outputs clear without a clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, i == 0, 1);
        @(negedge clk);
        pix_de = 1'b0;
        #1;
        reset = 1'b1;
        mode  = 0;
        px.delete();
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_wData", 32'(wData), 32'd0);
        chk("mid_rst_wAddr", 32'(wAddr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Two-bit pixels, 3-pixel frame: one padded write of 8'h27.
        @(negedge clk);
        reset2 = 1'b0;
        chk("d2_rst_busy", 32'(busy2), 32'd0);
        chk("d2_rst_we", 32'(we2), 32'd0);
        arm2  = 1'b1;
        cont2 = 1'b1;
        @(negedge clk);
        arm2  = 1'b0;
        de2   = 1'b1;
        sof2  = 1'b1;
        data2 = 2'b11;
        @(posedge clk);
        #1;
        chk("d2_we_p0", 32'(we2), 32'd0);
        chk("d2_busy_p0", 32'(busy2), 32'd1);
        @(negedge clk);
        sof2  = 1'b0;
        data2 = 2'b01;
        @(negedge clk);
        data2 = 2'b10;
        @(posedge clk);
        #1;
        chk("d2_we", 32'(we2), 32'd1);
        chk("d2_wData", 32'(wData2), 32'h27);
        chk("d2_wAddr", 32'(wAddr2), 32'd0);
        chk("d2_tick", 32'(tick2), 32'd1);
        chk("d2_busy", 32'(busy2), 32'd1);
        #1;
        reset2 = 1'b1;
        #1;
        chk("d2_rst_we2", 32'(we2), 32'd0);
        chk("d2_rst_wData2", 32'(wData2), 32'd0);
        chk("d2_rst_tick2", 32'(tick2), 32'd0);
        chk("d2_rst_busy2", 32'(busy2), 32'd0);
        @(negedge clk);
        de2 = 1'b0;

        repeat (3) @(negedge clk);
        chk("leftover_writes", 32'(wr_q.size()), 32'd0);
        chk("leftover_cycles", 32'(cyc_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
